// File: rtl/bus_trace_buffer.sv
// 6502 bus-cycle logic analyser: circular capture of {sync,rw,data,addr}
// per PHI2 falling edge, address/forced trigger, post-trigger count, freeze.
module bus_trace_buffer #(
   parameter  int DEPTH_LOG2 = 6,
   parameter  int ADDR_W     = 16,
   parameter  int DATA_W     = 8,
   localparam int ENTRY_W    = ADDR_W + DATA_W + 2,
   localparam int PTR_W      = DEPTH_LOG2,
   localparam int CNT_W      = DEPTH_LOG2 + 1
) (
   input  logic               CLK25MHZ,
   input  logic               rst_n,
   input  logic               phi2_sync,
   input  logic               rw_sync,
   input  logic               sync_sync,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [DATA_W-1:0]  data,
   input  logic               arm,
   input  logic               abort,
   input  logic               force_trig,
   input  logic [ADDR_W-1:0]  trig_mask,
   input  logic [ADDR_W-1:0]  trig_pattern,
   input  logic               trig_sync_only,
   input  logic [PTR_W-1:0]   post_cnt,
   input  logic [PTR_W-1:0]   rd_idx,
   output logic [ENTRY_W-1:0] rd_entry,
   output logic               armed,
   output logic               triggered,
   output logic               done,
   output logic [CNT_W-1:0]   fill,
   output logic [PTR_W-1:0]   trig_pos
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PRE  = 2'd1;
   localparam logic [1:0] S_POST = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1 << DEPTH_LOG2);

   logic [ENTRY_W-1:0] r_mem [2**DEPTH_LOG2];

   logic [1:0]         r_state;
   logic               r_phi2_prev;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_fill;
   logic [PTR_W-1:0]   r_trig_abs;
   logic [PTR_W-1:0]   r_rem;
   logic [PTR_W-1:0]   r_post_cnt;
   logic               r_force;
   logic [ADDR_W-1:0]  r_mask;
   logic [ADDR_W-1:0]  r_pat;
   logic               r_sync_only;
   logic [ENTRY_W-1:0] r_rd_entry;

   logic               w_cap;
   logic               w_capturing;
   logic               w_we;
   logic               w_match;
   logic [ENTRY_W-1:0] w_entry;
   logic [PTR_W-1:0]   w_oldest;
   logic [PTR_W-1:0]   w_rd_addr;

   assign w_cap       = r_phi2_prev & ~phi2_sync;
   assign w_capturing = (r_state == S_PRE) || (r_state == S_POST);
   // arm and abort both beat a coincident capture
   assign w_we        = w_cap & w_capturing & ~arm & ~abort;
   assign w_match     = (((addr ^ r_pat) & r_mask) == '0) &&
                        (!r_sync_only || sync_sync);
   assign w_entry     = {sync_sync, rw_sync, data, addr};
   assign w_oldest    = (r_fill == DEPTH_C) ? r_wr_ptr : '0;
   assign w_rd_addr   = w_oldest + rd_idx;

   always_ff @(posedge CLK25MHZ) begin
      if (w_we) r_mem[r_wr_ptr] <= w_entry;
   end

   always_ff @(posedge CLK25MHZ or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_phi2_prev <= 1'b0;
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_trig_abs  <= '0;
         r_rem       <= '0;
         r_post_cnt  <= '0;
         r_force     <= 1'b0;
         r_mask      <= '0;
         r_pat       <= '0;
         r_sync_only <= 1'b0;
         r_rd_entry  <= '0;
      end else begin
         r_phi2_prev <= phi2_sync;
         r_rd_entry  <= r_mem[w_rd_addr];
         if (arm) begin
            r_state     <= S_PRE;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_force     <= 1'b0;
            r_mask      <= trig_mask;
            r_pat       <= trig_pattern;
            r_sync_only <= trig_sync_only;
            r_post_cnt  <= post_cnt;
         end else if (abort) begin
            r_state <= S_IDLE;
         end else begin
            if (force_trig && r_state == S_PRE) r_force <= 1'b1;
            if (w_we) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
               if (r_fill != DEPTH_C) r_fill <= r_fill + 1'b1;
            end
            if (r_state == S_PRE && w_cap && (w_match || r_force)) begin
               r_trig_abs <= r_wr_ptr;
               r_force    <= 1'b0;
               r_rem      <= r_post_cnt;
               r_state    <= (r_post_cnt == '0) ? S_DONE : S_POST;
            end else if (r_state == S_POST && w_cap) begin
               r_rem <= r_rem - 1'b1;
               if (r_rem == PTR_W'(1)) r_state <= S_DONE;
            end
         end
      end
   end

   assign rd_entry  = r_rd_entry;
   assign armed     = w_capturing;
   assign triggered = (r_state == S_POST) || (r_state == S_DONE);
   assign done      = (r_state == S_DONE);
   assign fill      = r_fill;
   assign trig_pos  = r_trig_abs - w_oldest;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed bench for bus_trace_buffer: trigger, wrap, post=0,
// sync-only, forced trigger, arm/abort/reset interactions.
module tb_bus_trace_buffer;

   logic        CLK25MHZ = 1'b0;
   logic        rst_n = 1'b0;
   logic        phi2_sync = 1'b0;
   logic        rw_sync = 1'b1;
   logic        sync_sync = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  data = '0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic        force_trig = 1'b0;
   logic [15:0] trig_mask = '0;
   logic [15:0] trig_pattern = '0;
   logic        trig_sync_only = 1'b0;
   logic [5:0]  post_cnt = '0;
   logic [5:0]  rd_idx = '0;
   logic [25:0] rd_entry;
   logic        armed;
   logic        triggered;
   logic        done;
   logic [6:0]  fill;
   logic [5:0]  trig_pos;

   int total = 0;
   int bad = 0;

   bus_trace_buffer dut (
      .CLK25MHZ(CLK25MHZ), .rst_n(rst_n),
      .phi2_sync(phi2_sync), .rw_sync(rw_sync),
      .sync_sync(sync_sync), .addr(addr), .data(data),
      .arm(arm), .abort(abort), .force_trig(force_trig),
      .trig_mask(trig_mask), .trig_pattern(trig_pattern),
      .trig_sync_only(trig_sync_only), .post_cnt(post_cnt),
      .rd_idx(rd_idx), .rd_entry(rd_entry), .armed(armed),
      .triggered(triggered), .done(done), .fill(fill),
      .trig_pos(trig_pos)
   );

   always #20 CLK25MHZ = ~CLK25MHZ;

   task automatic bus_cyc(input logic [15:0] a, input logic [7:0] d,
                          input logic rw, input logic s);
      @(negedge CLK25MHZ);
      phi2_sync = 1'b1; addr = a; data = d; rw_sync = rw; sync_sync = s;
      @(negedge CLK25MHZ);
      phi2_sync = 1'b0;
      @(negedge CLK25MHZ);
   endtask

   task automatic do_arm(input logic [15:0] m, input logic [15:0] p,
                         input logic so, input logic [5:0] pc);
      @(negedge CLK25MHZ);
      trig_mask = m; trig_pattern = p; trig_sync_only = so;
      post_cnt = pc; arm = 1'b1;
      @(negedge CLK25MHZ);
      arm = 1'b0;
   endtask

   task automatic rd(input logic [5:0] i, output logic [25:0] e);
      @(negedge CLK25MHZ);
      rd_idx = i;
      @(negedge CLK25MHZ);
      e = rd_entry;
   endtask

   task automatic test_reset;
      #50;
      total++;
      if ({armed, triggered, done, fill, trig_pos, rd_entry} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got a=%b t=%b d=%b fill=%0d tp=%0d e=%h want 0",
                  armed, triggered, done, fill, trig_pos, rd_entry);
      end
      @(negedge CLK25MHZ);
      rst_n = 1'b1;
      @(negedge CLK25MHZ);
      total++;
      if ({armed, triggered, done, fill} !== '0) begin
         bad++;
         $display("FAIL reset_idle got a=%b t=%b d=%b fill=%0d want 0",
                  armed, triggered, done, fill);
      end
   endtask

   task automatic test_basic;
      logic [25:0] e;
      do_arm(16'hFF00, 16'hFF00, 1'b0, 6'd3);
      total++;
      if (armed !== 1'b1 || triggered !== 1'b0) begin
         bad++;
         $display("FAIL basic_armed got a=%b t=%b want 1 0", armed, triggered);
      end
      for (int n = 0; n < 10; n++) bus_cyc(16'h0200 + 16'(n), 8'(n), 1'b1, 1'b0);
      bus_cyc(16'hFF10, 8'hAA, 1'b1, 1'b0);
      total++;
      if (triggered !== 1'b1 || done !== 1'b0 || armed !== 1'b1) begin
         bad++;
         $display("FAIL basic_post got t=%b d=%b a=%b want 1 0 1",
                  triggered, done, armed);
      end
      for (int n = 0; n < 3; n++) bus_cyc(16'h0300 + 16'(n), 8'h00, 1'b1, 1'b0);
      total++;
      if (done !== 1'b1 || fill !== 7'd14 || trig_pos !== 6'd10) begin
         bad++;
         $display("FAIL basic_done got d=%b fill=%0d tp=%0d want 1 14 10",
                  done, fill, trig_pos);
      end
      rd(6'd10, e);
      total++;
      if (e[15:0] !== 16'hFF10) begin
         bad++;
         $display("FAIL basic_rd10 got %h want ff10", e[15:0]);
      end
      rd(6'd0, e);
      total++;
      if (e[15:0] !== 16'h0200) begin
         bad++;
         $display("FAIL basic_rd0 got %h want 0200", e[15:0]);
      end
   endtask

   task automatic test_wrap;
      logic [25:0] e;
      do_arm(16'hFF00, 16'hFF00, 1'b0, 6'd5);
      for (int n = 0; n < 100; n++) bus_cyc(16'(n), 8'h11, 1'b1, 1'b0);
      bus_cyc(16'hFF00, 8'h22, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) bus_cyc(16'h1000 + 16'(k), 8'h33, 1'b0, 1'b0);
      total++;
      if (done !== 1'b1 || fill !== 7'd64 || trig_pos !== 6'd58) begin
         bad++;
         $display("FAIL wrap_state got d=%b fill=%0d tp=%0d want 1 64 58",
                  done, fill, trig_pos);
      end
      rd(6'd0, e);
      total++;
      if (e[15:0] !== 16'd42) begin
         bad++;
         $display("FAIL wrap_rd0 got %h want 002a", e[15:0]);
      end
      rd(6'd63, e);
      total++;
      if (e[15:0] !== 16'h1004 || e[24] !== 1'b0) begin
         bad++;
         $display("FAIL wrap_rd63 got %h rw=%b want 1004 0", e[15:0], e[24]);
      end
      rd(6'd58, e);
      total++;
      if (e[15:0] !== 16'hFF00) begin
         bad++;
         $display("FAIL wrap_rdtrig got %h want ff00", e[15:0]);
      end
   endtask

   task automatic test_post_zero;
      do_arm(16'hFFFF, 16'h0003, 1'b0, 6'd0);
      for (int n = 0; n < 3; n++) bus_cyc(16'(n), 8'h00, 1'b1, 1'b0);
      total++;
      if (done !== 1'b0 || triggered !== 1'b0) begin
         bad++;
         $display("FAIL p0_early got d=%b t=%b want 0 0", done, triggered);
      end
      @(negedge CLK25MHZ);
      phi2_sync = 1'b1; addr = 16'h0003;
      @(negedge CLK25MHZ);
      phi2_sync = 1'b0;
      @(negedge CLK25MHZ);
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL p0_done got %b want 1", done);
      end
      bus_cyc(16'h0003, 8'h00, 1'b1, 1'b0);
      total++;
      if (fill !== 7'd4 || trig_pos !== 6'd3 || done !== 1'b1) begin
         bad++;
         $display("FAIL p0_frozen got fill=%0d tp=%0d d=%b want 4 3 1",
                  fill, trig_pos, done);
      end
   endtask

   task automatic test_sync_only;
      logic [25:0] e;
      do_arm(16'hFFFF, 16'h1234, 1'b1, 6'd0);
      bus_cyc(16'h1234, 8'h00, 1'b1, 1'b0);
      total++;
      if (triggered !== 1'b0) begin
         bad++;
         $display("FAIL so_nosync got %b want 0", triggered);
      end
      bus_cyc(16'h1234, 8'h5A, 1'b0, 1'b1);
      total++;
      if (done !== 1'b1 || trig_pos !== 6'd1) begin
         bad++;
         $display("FAIL so_trig got d=%b tp=%0d want 1 1", done, trig_pos);
      end
      rd(6'd1, e);
      total++;
      if (e !== {1'b1, 1'b0, 8'h5A, 16'h1234}) begin
         bad++;
         $display("FAIL so_entry got %h want %h", e, {1'b1, 1'b0, 8'h5A, 16'h1234});
      end
   endtask

   task automatic test_force;
      @(negedge CLK25MHZ);
      abort = 1'b1;
      @(negedge CLK25MHZ);
      abort = 1'b0; force_trig = 1'b1;
      @(negedge CLK25MHZ);
      force_trig = 1'b0;
      do_arm(16'hFFFF, 16'hFFFF, 1'b0, 6'd1);
      bus_cyc(16'h0001, 8'h00, 1'b1, 1'b0);
      total++;
      if (triggered !== 1'b0 || armed !== 1'b1) begin
         bad++;
         $display("FAIL force_idle got t=%b a=%b want 0 1", triggered, armed);
      end
      @(negedge CLK25MHZ);
      force_trig = 1'b1;
      @(negedge CLK25MHZ);
      force_trig = 1'b0;
      total++;
      if (triggered !== 1'b0) begin
         bad++;
         $display("FAIL force_nocap got %b want 0", triggered);
      end
      bus_cyc(16'h0002, 8'h00, 1'b1, 1'b0);
      total++;
      if (triggered !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL force_trig got t=%b d=%b want 1 0", triggered, done);
      end
      bus_cyc(16'h0003, 8'h00, 1'b1, 1'b0);
      total++;
      if (done !== 1'b1 || fill !== 7'd3 || trig_pos !== 6'd1) begin
         bad++;
         $display("FAIL force_done got d=%b fill=%0d tp=%0d want 1 3 1",
                  done, fill, trig_pos);
      end
   endtask

   task automatic test_arm_abort_reset;
      do_arm(16'hFFFF, 16'h00AA, 1'b0, 6'd4);
      @(negedge CLK25MHZ);
      phi2_sync = 1'b1; addr = 16'h00AA;
      @(negedge CLK25MHZ);
      phi2_sync = 1'b0; arm = 1'b1;
      @(negedge CLK25MHZ);
      arm = 1'b0;
      total++;
      if (fill !== 7'd0 || armed !== 1'b1 || triggered !== 1'b0) begin
         bad++;
         $display("FAIL arm_cap got fill=%0d a=%b t=%b want 0 1 0",
                  fill, armed, triggered);
      end
      bus_cyc(16'h00AA, 8'h00, 1'b1, 1'b0);
      bus_cyc(16'h0001, 8'h00, 1'b1, 1'b0);
      @(negedge CLK25MHZ);
      abort = 1'b1;
      @(negedge CLK25MHZ);
      abort = 1'b0;
      total++;
      if (armed !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 || fill !== 7'd2) begin
         bad++;
         $display("FAIL abort got a=%b t=%b d=%b fill=%0d want 0 0 0 2",
                  armed, triggered, done, fill);
      end
      do_arm(16'hFFFF, 16'h00AA, 1'b0, 6'd4);
      bus_cyc(16'h00AA, 8'h00, 1'b1, 1'b0);
      bus_cyc(16'h0001, 8'h00, 1'b1, 1'b0);
      total++;
      if (triggered !== 1'b1 || armed !== 1'b1) begin
         bad++;
         $display("FAIL pre_rst got t=%b a=%b want 1 1", triggered, armed);
      end
      #5 rst_n = 1'b0;
      #1;
      total++;
      if ({armed, triggered, done, fill, trig_pos, rd_entry} !== '0) begin
         bad++;
         $display("FAIL async_rst got a=%b t=%b d=%b fill=%0d tp=%0d e=%h want 0",
                  armed, triggered, done, fill, trig_pos, rd_entry);
      end
      @(negedge CLK25MHZ);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_post_zero();
      test_sync_only();
      test_force();
      test_arm_abort_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
